sd_clk_rate_controller: RTL and testbench
=========================================

// Module: sd_clk_rate_controller
// PURPOSE
// Sequences SD bus clock-rate changes for the host controller. Holds the identification-rate
// divider count after reset. On request, either restores that count or runs the clock-divider
// count generator on the card's TRAN_SPEED byte, then hands the result to the SD clock divider.
// The SD clock is gated quiet around every count change so the card never sees a runt pulse.
// PARAMETERS
// ID_COUNT     16'd63  divider count for the ~400 kHz identification clock (50 MHz ref)
// MIN_COUNT    16'd1   floor on the applied count; smaller generator results are clamped to it
// TIMEOUT      8'd255  cycles to wait for gen_ok/gen_err before declaring an error
// GATE_CYCLES  4'd4    clk cycles sd_clk_en is held low before and after a count load
// PORTS
// clk          in   1   system clock (50 MHz)
// reset        in   1   asynchronous, active-low reset
// req_id       in   1   1-cycle pulse: switch to ID_COUNT
// req_fast     in   1   1-cycle pulse: switch to the rate encoded by tran_speed
// tran_speed   in   8   CSD TRAN_SPEED byte; sampled on the cycle req_fast is accepted
// gen_start    out  1   1-cycle start pulse to the count generator
// gen_speed    out  8   latched TRAN_SPEED value driven to the count generator
// gen_ok       in   1   generator result valid (1-cycle pulse)
// gen_err      in   1   generator error, e.g. divide by zero (1-cycle pulse)
// gen_count    in   16  generator result; valid when gen_ok=1
// div_count    out  16  count currently applied to the SD clock divider
// div_load     out  1   1-cycle pulse: divider reloads div_count and restarts its phase
// sd_clk_en    out  1   SD clock output enable (0 = clock held low)
// busy         out  1   1 while not in IDLE
// done         out  1   1-cycle pulse at the end of every accepted request
// err          out  1   sticky; set on gen_err or timeout, cleared when the next request is accepted
// clamped      out  1   sticky; last fast request was clamped to MIN_COUNT
// fast_mode    out  1   1 when div_count came from the generator; 0 when it is ID_COUNT
// BEHAVIOUR
// Reset values (async, reset=0):
// - state=IDLE; div_count=ID_COUNT; sd_clk_en=1.
// - gen_start, div_load, done, busy, err, clamped, fast_mode = 0; gen_speed=0.
// States: IDLE, START, WAIT, GATE_PRE, LOAD, GATE_POST.
// IDLE: requests are accepted only here. Both requests in the same cycle: req_id wins,
//   req_fast is dropped. Requests while busy are ignored and not queued.
// - Accept clears err; a fast accept also clears clamped.
// - req_id -> GATE_PRE with pending=ID_COUNT and pending_fast=0.
// - req_fast -> latch tran_speed into gen_speed -> START.
// START: gen_start=1 for exactly 1 cycle; timer cleared -> WAIT.
// WAIT: timer increments each cycle.
// - gen_ok: pending = (gen_count < MIN_COUNT) ? MIN_COUNT : gen_count; set clamped if clamped;
//   pending_fast=1 -> GATE_PRE.
// - gen_err, or timer reaching TIMEOUT: set err, pulse done -> IDLE. div_count, sd_clk_en and
//   fast_mode are unchanged.
// - gen_ok and gen_err in the same cycle: err wins.
// GATE_PRE: sd_clk_en=0 for GATE_CYCLES cycles -> LOAD.
// LOAD: div_count<=pending, fast_mode<=pending_fast, div_load=1 for 1 cycle -> GATE_POST.
// GATE_POST: sd_clk_en stays 0 for GATE_CYCLES cycles -> IDLE. sd_clk_en=1 and done=1 in that
//   first IDLE cycle.
// busy=1 in every state except IDLE.
// Latency, req_id accept to done: 2*GATE_CYCLES+2 cycles (10 at defaults).
// Latency, req_fast: START + generator latency + 2*GATE_CYCLES + 2 cycles.
// GATE_CYCLES=0 is legal: GATE_PRE and GATE_POST each last one cycle.
// Re-requesting the current rate still performs the full gate/load sequence.
// Asserting reset mid-operation aborts immediately to the reset values; no partial load survives.
// TESTING
// - Release reset, idle 20 cycles -> div_count=63, sd_clk_en=1, busy=0, no div_load pulse.
// - req_fast with tran_speed=8'h32; stub gen_ok with gen_count=8 after 40 cycles -> exactly one
//   gen_start, gen_speed=8'h32, sd_clk_en low 4 cycles before and 4 after div_load,
//   div_count=8, fast_mode=1, one done pulse.
// - req_fast with tran_speed=8'h00; stub gen_err -> err=1, done pulse, div_count stays 63,
//   sd_clk_en never drops. Next req_id accept clears err.
// - Generator stub silent -> err=1 exactly TIMEOUT(255) cycles after gen_start; a gen_ok arriving
//   later is ignored.
// - gen_count=0 -> div_count=1, clamped=1. Then req_id and req_fast in the same cycle ->
//   ID path taken, div_count=63, fast_mode=0, no gen_start.
// - Pull reset low during GATE_PRE of a fast request -> outputs return to reset values at once;
//   after release, div_count=63 and no stray div_load.

Source files
------------

// File: rtl/sd_clk_rate_controller.sv
// ============================================================================
// Module      : sd_clk_rate_controller
// Description : Sequences SD bus clock-rate changes. Holds the identification
//               divider count after reset and, on request, either restores it
//               or asks the count generator for a TRAN_SPEED-derived count.
//               The SD clock is gated quiet around every divider reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_clk_rate_controller #(
  parameter logic [15:0] ID_COUNT    = 16'd63,
  parameter logic [15:0] MIN_COUNT   = 16'd1,
  parameter logic [7:0]  TIMEOUT     = 8'd255,
  parameter logic [3:0]  GATE_CYCLES = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_id,
  input  logic        i_req_fast,
  input  logic [7:0]  i_tran_speed,
  output logic        o_gen_start,
  output logic [7:0]  o_gen_speed,
  input  logic        i_gen_ok,
  input  logic        i_gen_err,
  input  logic [15:0] i_gen_count,
  output logic [15:0] o_div_count,
  output logic        o_div_load,
  output logic        o_sd_clk_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_clamped,
  output logic        o_fast_mode
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT      = 3'd2,
    S_GATE_PRE  = 3'd3,
    S_LOAD      = 3'd4,
    S_GATE_POST = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_pending;
  logic        r_pending_fast;
  logic [3:0]  r_gate_cnt;
  logic [7:0]  r_timer;
  logic        r_gen_start;
  logic [7:0]  r_gen_speed;
  logic [15:0] r_div_count;
  logic        r_div_load;
  logic        r_sd_clk_en;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_clamped;
  logic        r_fast_mode;

  // A gate phase always lasts at least one cycle, so GATE_CYCLES=0 behaves as 1.
  logic        w_gate_last;
  // r_timer counts cycles elapsed since the gen_start cycle; the timeout fires
  // so that err appears exactly TIMEOUT cycles after gen_start.
  logic        w_timeout;
  logic        w_gen_clamp;
  logic [15:0] w_gen_result;

  assign w_gate_last  = ({1'b0, r_gate_cnt} + 5'd1) >= {1'b0, GATE_CYCLES};
  assign w_timeout    = ({1'b0, r_timer} + 9'd1) >= {1'b0, TIMEOUT};
  assign w_gen_clamp  = i_gen_count < MIN_COUNT;
  assign w_gen_result = w_gen_clamp ? MIN_COUNT : i_gen_count;

  // Rate-change sequencer: accept, generate, gate, load, gate, release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pending      <= ID_COUNT;
      r_pending_fast <= 1'b0;
      r_gate_cnt     <= 4'd0;
      r_timer        <= 8'd0;
      r_gen_start    <= 1'b0;
      r_gen_speed    <= 8'd0;
      r_div_count    <= ID_COUNT;
      r_div_load     <= 1'b0;
      r_sd_clk_en    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_clamped      <= 1'b0;
      r_fast_mode    <= 1'b0;
    end else begin
      r_gen_start <= 1'b0;
      r_div_load  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // req_id has priority; requests outside IDLE are simply not seen.
          if (i_req_id) begin
            r_err          <= 1'b0;
            r_pending      <= ID_COUNT;
            r_pending_fast <= 1'b0;
            r_gate_cnt     <= 4'd0;
            r_sd_clk_en    <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= S_GATE_PRE;
          end else if (i_req_fast) begin
            r_err       <= 1'b0;
            r_clamped   <= 1'b0;
            r_gen_speed <= i_tran_speed;
            r_gen_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_timer <= 8'd1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Error beats a simultaneous result; a result beats the timeout.
          if (i_gen_err) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (i_gen_ok) begin
            r_pending      <= w_gen_result;
            r_pending_fast <= 1'b1;
            if (w_gen_clamp) begin
              r_clamped <= 1'b1;
            end
            r_gate_cnt  <= 4'd0;
            r_sd_clk_en <= 1'b0;
            r_state     <= S_GATE_PRE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_GATE_PRE: begin
          // New count and load strobe become visible together in LOAD.
          if (w_gate_last) begin
            r_div_count <= r_pending;
            r_fast_mode <= r_pending_fast;
            r_div_load  <= 1'b1;
            r_state     <= S_LOAD;
          end else begin
            r_gate_cnt <= r_gate_cnt + 4'd1;
          end
        end
        S_LOAD: begin
          r_gate_cnt <= 4'd0;
          r_state    <= S_GATE_POST;
        end
        S_GATE_POST: begin
          if (w_gate_last) begin
            r_sd_clk_en <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_gate_cnt <= r_gate_cnt + 4'd1;
          end
        end
        default: begin
          r_sd_clk_en <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gen_start = r_gen_start;
  assign o_gen_speed = r_gen_speed;
  assign o_div_count = r_div_count;
  assign o_div_load  = r_div_load;
  assign o_sd_clk_en = r_sd_clk_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_clamped   = r_clamped;
  assign o_fast_mode = r_fast_mode;

endmodule

`default_nettype wire

// File: tb/tb_sd_clk_rate_controller.sv
// ============================================================================
// Module      : tb_sd_clk_rate_controller
// Description : Self-checking bench. A timeline model paints the expected
//               output waveform from each accepted request; every cycle is
//               compared, and directed literal checks pin the key numbers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sd_clk_rate_controller;

  localparam int          N    = 4096;
  localparam int          G    = 4;
  localparam int          TO   = 255;
  localparam logic [15:0] IDC  = 16'd63;
  localparam logic [15:0] MINC = 16'd1;

  localparam int L_COUNT = 0;
  localparam int L_SPEED = 1;
  localparam int L_EN    = 2;
  localparam int L_BUSY  = 3;
  localparam int L_ERR   = 4;
  localparam int L_CLAMP = 5;
  localparam int L_FAST  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_id = 1'b0;
  logic        i_req_fast = 1'b0;
  logic [7:0]  i_tran_speed = 8'h00;
  logic        i_gen_ok = 1'b0;
  logic        i_gen_err = 1'b0;
  logic [15:0] i_gen_count = 16'h0000;
  logic        o_gen_start;
  logic [7:0]  o_gen_speed;
  logic [15:0] o_div_count;
  logic        o_div_load;
  logic        o_sd_clk_en;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_clamped;
  logic        o_fast_mode;

  sd_clk_rate_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_id    (i_req_id),
    .i_req_fast  (i_req_fast),
    .i_tran_speed(i_tran_speed),
    .o_gen_start (o_gen_start),
    .o_gen_speed (o_gen_speed),
    .i_gen_ok    (i_gen_ok),
    .i_gen_err   (i_gen_err),
    .i_gen_count (i_gen_count),
    .o_div_count (o_div_count),
    .o_div_load  (o_div_load),
    .o_sd_clk_en (o_sd_clk_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_clamped   (o_clamped),
    .o_fast_mode (o_fast_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Expected waveform, indexed by cycle number
  logic [15:0] e_count [N];
  logic [7:0]  e_speed [N];
  logic        e_en    [N];
  logic        e_busy  [N];
  logic        e_err   [N];
  logic        e_clamp [N];
  logic        e_fast  [N];
  logic        e_gs    [N];
  logic        e_load  [N];
  logic        e_done  [N];
  bit          m_wait = 1'b0;
  int          m_gs = 0;

  // Pulse / event monitors
  int n_gs = 0, n_load = 0, n_done = 0, n_en_low = 0;
  int c_load = 0, c_done = 0, c_fall = 0;
  logic prev_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic lvl(input int sel, input int from, input logic [15:0] v);
    for (int k = from; k < N; k++) begin
      case (sel)
        L_COUNT: e_count[k] = v;
        L_SPEED: e_speed[k] = v[7:0];
        L_EN:    e_en[k]    = v[0];
        L_BUSY:  e_busy[k]  = v[0];
        L_ERR:   e_err[k]   = v[0];
        L_CLAMP: e_clamp[k] = v[0];
        default: e_fast[k]  = v[0];
      endcase
    end
  endtask

  task automatic model_reset(input int from);
    lvl(L_COUNT, from, IDC);
    lvl(L_SPEED, from, 16'd0);
    lvl(L_EN,    from, 16'd1);
    lvl(L_BUSY,  from, 16'd0);
    lvl(L_ERR,   from, 16'd0);
    lvl(L_CLAMP, from, 16'd0);
    lvl(L_FAST,  from, 16'd0);
    for (int k = from; k < N; k++) begin
      e_gs[k] = 1'b0; e_load[k] = 1'b0; e_done[k] = 1'b0;
    end
    m_wait = 1'b0;
  endtask

  // Clock quiet for G cycles, one load cycle, quiet for G cycles, then done.
  task automatic gate_seq(input int s, input logic [15:0] cnt, input logic fast);
    lvl(L_BUSY, s, 16'd1);
    lvl(L_EN,   s, 16'd0);
    lvl(L_COUNT, s + G, cnt);
    lvl(L_FAST,  s + G, {15'd0, fast});
    lvl(L_BUSY, s + 2*G + 1, 16'd0);
    lvl(L_EN,   s + 2*G + 1, 16'd1);
    if (s + G < N) e_load[s + G] = 1'b1;
    if (s + 2*G + 1 < N) e_done[s + 2*G + 1] = 1'b1;
  endtask

  task automatic fast_fail(input int p);
    lvl(L_ERR, p, 16'd1);
    lvl(L_BUSY, p, 16'd0);
    e_done[p] = 1'b1;
    m_wait = 1'b0;
  endtask

  // Inputs seen at edge p belong to cycle p-1; effects show from cycle p.
  task automatic model_step(input int p);
    if (!e_busy[p-1]) begin
      if (i_req_id) begin
        lvl(L_ERR, p, 16'd0);
        gate_seq(p, IDC, 1'b0);
      end else if (i_req_fast) begin
        lvl(L_ERR, p, 16'd0);
        lvl(L_CLAMP, p, 16'd0);
        lvl(L_SPEED, p, {8'd0, i_tran_speed});
        lvl(L_BUSY, p, 16'd1);
        e_gs[p] = 1'b1;
        m_wait = 1'b1;
        m_gs = p;
      end
    end else if (m_wait && (p - 1) > m_gs) begin
      if (i_gen_err) begin
        fast_fail(p);
      end else if (i_gen_ok) begin
        if (i_gen_count < MINC) lvl(L_CLAMP, p, 16'd1);
        gate_seq(p, (i_gen_count < MINC) ? MINC : i_gen_count, 1'b1);
        m_wait = 1'b0;
      end else if (p - m_gs >= TO) begin
        fast_fail(p);
      end
    end
  endtask

  initial model_reset(0);

  always @(negedge rst_n) model_reset(cyc);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && cyc < N - 1) model_step(cyc);
  end

  // Per-cycle comparison against the model plus pulse bookkeeping
  always @(negedge clk) begin
    if (cyc < N) begin
      chk("div_count", {16'd0, o_div_count}, {16'd0, e_count[cyc]});
      chk("gen_speed", {24'd0, o_gen_speed}, {24'd0, e_speed[cyc]});
      chk("sd_clk_en", {31'd0, o_sd_clk_en}, {31'd0, e_en[cyc]});
      chk("busy",      {31'd0, o_busy},      {31'd0, e_busy[cyc]});
      chk("err",       {31'd0, o_err},       {31'd0, e_err[cyc]});
      chk("clamped",   {31'd0, o_clamped},   {31'd0, e_clamp[cyc]});
      chk("fast_mode", {31'd0, o_fast_mode}, {31'd0, e_fast[cyc]});
      chk("gen_start", {31'd0, o_gen_start}, {31'd0, e_gs[cyc]});
      chk("div_load",  {31'd0, o_div_load},  {31'd0, e_load[cyc]});
      chk("done",      {31'd0, o_done},      {31'd0, e_done[cyc]});
    end
    if (o_gen_start) n_gs++;
    if (o_div_load) begin n_load++; c_load = cyc; end
    if (o_done) begin n_done++; c_done = cyc; end
    if (!o_sd_clk_en) n_en_low++;
    if (prev_en && !o_sd_clk_en) c_fall = cyc;
    prev_en = o_sd_clk_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fast(input logic [7:0] spd);
    i_tran_speed = spd;
    i_req_fast = 1'b1;
    tick();
    i_req_fast = 1'b0;
    i_tran_speed = 8'hA5;
  endtask

  task automatic wait_gs(output int gs);
    int k = 0;
    while (!o_gen_start && k < 5) begin tick(); k++; end
    chk("gen_start_seen", {31'd0, o_gen_start}, 32'd1);
    gs = cyc;
  endtask

  task automatic gen_reply(input int dly, input bit ok, input logic [15:0] cnt);
    repeat (dly) tick();
    i_gen_ok = ok;
    i_gen_err = !ok;
    i_gen_count = cnt;
    tick();
    i_gen_ok = 1'b0;
    i_gen_err = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!o_done && k < 400) begin tick(); k++; end
    chk(nm, {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int gs, c0, b_gs, b_load, b_done, b_low;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_count", {16'd0, o_div_count}, 32'd63);
    chk("idle_en", {31'd0, o_sd_clk_en}, 32'd1);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_no_load", n_load, 32'd0);

    // Fast request, generator answers 8 after 40 cycles
    b_gs = n_gs; b_load = n_load; b_done = n_done; b_low = n_en_low;
    pulse_fast(8'h32);
    wait_gs(gs);
    gen_reply(40, 1'b1, 16'd8);
    wait_done("fast_done");
    tick();
    chk("fast_count", {16'd0, o_div_count}, 32'd8);
    chk("fast_mode", {31'd0, o_fast_mode}, 32'd1);
    chk("fast_speed", {24'd0, o_gen_speed}, 32'h32);
    chk("fast_one_gs", n_gs - b_gs, 32'd1);
    chk("fast_one_load", n_load - b_load, 32'd1);
    chk("fast_one_done", n_done - b_done, 32'd1);
    chk("fast_en_low", n_en_low - b_low, 32'd9);
    chk("fast_pre_gate", c_load - c_fall, 32'd4);
    chk("fast_post_gate", c_done - c_load, 32'd5);
    chk("fast_lat", c_done - gs, 32'd50);

    // ID request latency
    c0 = cyc;
    i_req_id = 1'b1; tick(); i_req_id = 1'b0;
    wait_done("id_done");
    chk("id_latency", cyc - c0, 32'd10);
    chk("id_count", {16'd0, o_div_count}, 32'd63);

    // Generator error: clock never gated, count kept
    tick();
    b_low = n_en_low; b_load = n_load;
    pulse_fast(8'h00);
    wait_gs(gs);
    gen_reply(3, 1'b0, 16'd0);
    wait_done("err_done");
    chk("err_set", {31'd0, o_err}, 32'd1);
    tick();
    chk("err_count", {16'd0, o_div_count}, 32'd63);
    chk("err_en_kept", n_en_low - b_low, 32'd0);
    chk("err_no_load", n_load - b_load, 32'd0);
    i_req_id = 1'b1; tick(); i_req_id = 1'b0;
    chk("err_cleared", {31'd0, o_err}, 32'd0);
    wait_done("err_id_done");
    tick();

    // Silent generator: timeout, then a late gen_ok is ignored
    b_load = n_load;
    pulse_fast(8'h5A);
    wait_gs(gs);
    c0 = 0;
    while (!o_err && c0 < 300) begin tick(); c0++; end
    chk("to_delay", cyc - gs, 32'd255);
    chk("to_done", {31'd0, o_done}, 32'd1);
    repeat (5) tick();
    gen_reply(0, 1'b1, 16'd5);
    repeat (5) tick();
    chk("to_late_ok", {16'd0, o_div_count}, 32'd63);
    chk("to_no_load", n_load - b_load, 32'd0);
    chk("to_idle", {31'd0, o_busy}, 32'd0);

    // Clamp to MIN_COUNT, then simultaneous requests take the ID path
    pulse_fast(8'h11);
    wait_gs(gs);
    gen_reply(3, 1'b1, 16'd0);
    wait_done("clamp_done");
    chk("clamp_count", {16'd0, o_div_count}, 32'd1);
    chk("clamp_flag", {31'd0, o_clamped}, 32'd1);
    tick();
    b_gs = n_gs;
    i_req_id = 1'b1; i_req_fast = 1'b1; i_tran_speed = 8'h77;
    tick();
    i_req_id = 1'b0; i_req_fast = 1'b0;
    repeat (3) tick();
    pulse_fast(8'h22);
    wait_done("both_done");
    tick();
    chk("both_count", {16'd0, o_div_count}, 32'd63);
    chk("both_fast", {31'd0, o_fast_mode}, 32'd0);
    chk("both_no_gs", n_gs - b_gs, 32'd0);
    chk("both_clamp_kept", {31'd0, o_clamped}, 32'd1);

    // Reset during GATE_PRE of a fast request
    pulse_fast(8'h2A);
    wait_gs(gs);
    gen_reply(2, 1'b1, 16'd20);
    tick();
    b_load = n_load;
    rst_n = 1'b0;
    #1;
    chk("rst_count", {16'd0, o_div_count}, 32'd63);
    chk("rst_en", {31'd0, o_sd_clk_en}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_speed", {24'd0, o_gen_speed}, 32'd0);
    chk("rst_clamp", {31'd0, o_clamped}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_after_count", {16'd0, o_div_count}, 32'd63);
    chk("rst_no_load", n_load - b_load, 32'd0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
